// File: rtl/vdp_init_sequencer.sv
// Script-driven bus master for VDP bring-up: replays ROM entries as interlocked
// SEL/DTACK_N cycles (register/data writes, status reads, delays).
module vdp_init_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 4095
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              SEL,
    output logic [3:0]        A,
    output logic              RNW,
    output logic              UDS_N,
    output logic              LDS_N,
    output logic [15:0]       DI,
    input  logic [15:0]       DO,
    input  logic              DTACK_N,
    output logic [15:0]       status
);

    localparam int TO_W = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    // BUS_REQ holds SEL until ack; BUS_REL waits for DTACK_N to return high.
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_BUS_REQ,
        S_BUS_REL,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              sel_nxt, rnw_nxt, uds_nxt, lds_nxt;
    logic [3:0]        a_nxt;
    logic [15:0]       di_nxt, status_nxt;
    logic              busy_nxt, done_nxt, error_nxt;
    logic [15:0]       dly_cnt, dly_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic              dtack_meta, dtack_sync;

    logic [1:0]  op;
    logic [1:0]  be;
    logic [15:0] payload;

    assign op      = rom_data[23:22];
    assign be      = (rom_data[21:20] == 2'b00) ? 2'b11 : rom_data[21:20];
    assign payload = rom_data[15:0];

    always_comb begin
        state_nxt  = state;
        addr_nxt   = rom_addr;
        sel_nxt    = SEL;
        a_nxt      = A;
        rnw_nxt    = RNW;
        uds_nxt    = UDS_N;
        lds_nxt    = LDS_N;
        di_nxt     = DI;
        busy_nxt   = busy;
        done_nxt   = done;
        error_nxt  = error;
        status_nxt = status;
        dly_nxt    = dly_cnt;
        to_nxt     = to_cnt;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    addr_nxt  = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                end
            end

            S_FETCH: state_nxt = S_DECODE;

            S_DECODE: begin
                case (op)
                    OP_WRITE, OP_READ: begin
                        state_nxt = S_BUS_REQ;
                        sel_nxt   = 1'b1;
                        a_nxt     = rom_data[19:16];
                        di_nxt    = payload;
                        rnw_nxt   = (op == OP_READ);
                        uds_nxt   = ~be[1];
                        lds_nxt   = ~be[0];
                        to_nxt    = '0;
                    end
                    OP_DELAY: begin
                        if (payload == 16'd0) begin
                            state_nxt = S_NEXT;
                        end else begin
                            state_nxt = S_DELAY;
                            dly_nxt   = payload;
                        end
                    end
                    default: begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                endcase
            end

            S_BUS_REQ: begin
                if (!dtack_sync) begin
                    if (RNW) begin
                        status_nxt = DO;
                    end
                    state_nxt = S_BUS_REL;
                    sel_nxt   = 1'b0;
                    rnw_nxt   = 1'b1;
                    uds_nxt   = 1'b1;
                    lds_nxt   = 1'b1;
                    to_nxt    = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_ERR;
                    sel_nxt   = 1'b0;
                    rnw_nxt   = 1'b1;
                    uds_nxt   = 1'b1;
                    lds_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    error_nxt = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end

            S_BUS_REL: begin
                if (dtack_sync) begin
                    state_nxt = S_NEXT;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_ERR;
                    busy_nxt  = 1'b0;
                    error_nxt = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end

            S_DELAY: begin
                if (dly_cnt == 16'd1) begin
                    state_nxt = S_NEXT;
                end else begin
                    dly_nxt = dly_cnt - 16'd1;
                end
            end

            S_NEXT: begin
                // Running off the end of the ROM is an error; the address never wraps.
                if (rom_addr == ADDR_LAST) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    state_nxt = S_FETCH;
                    addr_nxt  = rom_addr + 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            SEL        <= 1'b0;
            A          <= 4'd0;
            RNW        <= 1'b1;
            UDS_N      <= 1'b1;
            LDS_N      <= 1'b1;
            DI         <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            status     <= 16'd0;
            dly_cnt    <= 16'd0;
            to_cnt     <= '0;
            dtack_meta <= 1'b1;
            dtack_sync <= 1'b1;
        end else begin
            state      <= state_nxt;
            rom_addr   <= addr_nxt;
            SEL        <= sel_nxt;
            A          <= a_nxt;
            RNW        <= rnw_nxt;
            UDS_N      <= uds_nxt;
            LDS_N      <= lds_nxt;
            DI         <= di_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            status     <= status_nxt;
            dly_cnt    <= dly_nxt;
            to_cnt     <= to_nxt;
            dtack_meta <= DTACK_N;
            dtack_sync <= dtack_meta;
        end
    end

endmodule

// File: tb/tb_vdp_init_sequencer.sv
// Scoreboard bench for vdp_init_sequencer: ROM model, VDP handshake model,
// bus-cycle and completion monitors fed by expectation queues.
module tb_vdp_init_sequencer;

    localparam int ADDR_W = 2;
    localparam logic [23:0] OP_END = 24'hC00000;

    logic              clk = 1'b0;
    logic              CPU_RESETN;
    logic              start;
    logic              busy, done, error;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data = 24'h0;
    logic              SEL, RNW, UDS_N, LDS_N;
    logic [3:0]        A;
    logic [15:0]       DI;
    logic [15:0]       do_v = 16'h0;
    logic              DTACK_N = 1'b1;
    logic [15:0]       status;

    vdp_init_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(4095)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(CPU_RESETN),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .SEL       (SEL),
        .A         (A),
        .RNW       (RNW),
        .UDS_N     (UDS_N),
        .LDS_N     (LDS_N),
        .DI        (DI),
        .DO        (do_v),
        .DTACK_N   (DTACK_N),
        .status    (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] di;
        logic        rnw;
        logic        uds_n;
        logic        lds_n;
        int          rise;
        int          hold;
    } bus_t;

    typedef struct {
        logic              done_v;
        logic              error_v;
        logic [15:0]       status_v;
        logic [ADDR_W-1:0] addr_v;
    } res_t;

    bus_t exp_q[$];
    res_t res_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st_cyc = 0;
    int dtack_cyc = 0;
    int ack_budget = 0;
    int acks_done = 0;
    int ack_delay = 5;
    logic [15:0] read_val = 16'h0;
    logic [23:0] rom [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk) rom_data <= rom[rom_addr];

    // VDP model: acks after ack_delay cycles while budget remains, holds DTACK_N
    // low until SEL drops, then releases it two cycles later.
    initial forever begin
        @(negedge clk);
        if (SEL === 1'b1) begin
            if (acks_done < ack_budget) begin
                acks_done++;
                repeat (ack_delay) @(posedge clk);
                #1;
                dtack_cyc = cyc;
                do_v      = read_val;
                DTACK_N   = 1'b0;
                while (SEL !== 1'b0) @(negedge clk);
                repeat (2) @(posedge clk);
                #1;
                DTACK_N = 1'b1;
                do_v    = 16'h0;
            end else begin
                while (SEL !== 1'b0) @(negedge clk);
            end
        end
    end

    logic        sel_prev = 1'b0;
    logic        busy_prev = 1'b0;
    logic        have_exp = 1'b0;
    logic        stable_ok = 1'b1;
    int          rise_cyc = 0;
    logic [24:0] bus_snap = '0;
    bus_t        e;
    res_t        r;

    initial forever begin
        @(negedge clk);
        if (!sel_prev && SEL === 1'b1) begin
            rise_cyc  = cyc;
            bus_snap  = {A, DI, RNW, UDS_N, LDS_N, 2'b00};
            stable_ok = 1'b1;
            if (exp_q.size() == 0) begin
                have_exp = 1'b0;
                check("unexpected_bus_cycle", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                have_exp = 1'b1;
                check("bus_A", 32'(A), 32'(e.a));
                check("bus_DI", 32'(DI), 32'(e.di));
                check("bus_RNW", 32'(RNW), 32'(e.rnw));
                check("bus_strobes", 32'({UDS_N, LDS_N}), 32'({e.uds_n, e.lds_n}));
                if (e.rise >= 0) check("sel_rise_cycle", 32'(cyc), 32'(e.rise));
            end
        end else if (sel_prev && SEL === 1'b1) begin
            if ({A, DI, RNW, UDS_N, LDS_N, 2'b00} !== bus_snap) stable_ok = 1'b0;
        end else if (sel_prev && SEL !== 1'b1) begin
            if (have_exp) begin
                check("bus_stable_during_sel", 32'(stable_ok), 32'd1);
                if (e.hold >= 0) check("sel_hold_cycles", 32'(cyc - rise_cyc), 32'(e.hold));
                if (DTACK_N === 1'b0) check("sel_fall_after_dtack", 32'(cyc - dtack_cyc), 32'd3);
            end
        end
        if (busy_prev && busy === 1'b0) begin
            if (res_q.size() == 0) begin
                check("unexpected_completion", 32'(res_q.size()), 32'd1);
            end else begin
                r = res_q.pop_front();
                check("done", 32'(done), 32'(r.done_v));
                check("error", 32'(error), 32'(r.error_v));
                check("status", 32'(status), 32'(r.status_v));
                check("rom_addr_at_end", 32'(rom_addr), 32'(r.addr_v));
            end
        end
        sel_prev  = (SEL === 1'b1);
        busy_prev = (busy === 1'b1);
    end

    task automatic load(input logic [23:0] e0, input logic [23:0] e1,
                        input logic [23:0] e2, input logic [23:0] e3);
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        rom[3] = e3;
    endtask

    task automatic push_bus(input logic [3:0] a, input logic [15:0] di, input logic rnw,
                            input logic uds_n, input logic lds_n, input int rise, input int hold);
        bus_t b;
        b.a = a; b.di = di; b.rnw = rnw; b.uds_n = uds_n; b.lds_n = lds_n;
        b.rise = rise; b.hold = hold;
        exp_q.push_back(b);
    endtask

    task automatic push_res(input logic d, input logic er, input logic [15:0] s,
                            input logic [ADDR_W-1:0] ad);
        res_t x;
        x.done_v = d; x.error_v = er; x.status_v = s; x.addr_v = ad;
        res_q.push_back(x);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start  = 1'b1;
        st_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_script(input string name, input int limit);
        for (int i = 0; i < limit && res_q.size() != 0; i++) @(posedge clk);
        if (res_q.size() != 0) begin
            check({name, "_completion_timeout"}, 32'(res_q.size()), 32'd0);
            res_q.delete();
        end
        repeat (8) @(posedge clk);
        check({name, "_bus_cycles_consumed"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CPU_RESETN = 1'b0;
        start      = 1'b0;
        load(OP_END, OP_END, OP_END, OP_END);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_SEL", 32'(SEL), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_RNW", 32'(RNW), 32'd1);
        check("rst_strobes", 32'({UDS_N, LDS_N}), 32'd3);
        check("rst_DI", 32'(DI), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_flags", 32'({busy, done, error}), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        @(posedge clk);
        #1;
        CPU_RESETN = 1'b1;
        repeat (3) @(posedge clk);

        // single write, ack after 5 cycles
        load(24'h328174, OP_END, OP_END, OP_END);
        ack_budget += 1;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        push_bus(4'd2, 16'h8174, 1'b0, 1'b0, 1'b0, st_cyc + 3, -1);
        push_res(1'b1, 1'b0, 16'h0000, 2'd1);
        run_script("write", 200);

        // status read, BE=00 treated as both bytes
        load(24'h420000, OP_END, OP_END, OP_END);
        read_val = 16'h3608;
        ack_budget += 1;
        pulse_start();
        push_bus(4'd2, 16'h0000, 1'b1, 1'b0, 1'b0, st_cyc + 3, -1);
        push_res(1'b1, 1'b0, 16'h3608, 2'd1);
        run_script("read", 200);

        // DELAY 100 then lower-byte write: 2 + 100 + NEXT/FETCH/DECODE + 1
        load(24'h800064, 24'h100EEE, OP_END, OP_END);
        ack_budget += 1;
        pulse_start();
        push_bus(4'd0, 16'h0EEE, 1'b0, 1'b1, 1'b0, st_cyc + 106, -1);
        push_res(1'b1, 1'b0, 16'h3608, 2'd2);
        run_script("delay", 400);

        // no ack: SEL held for exactly TIMEOUT cycles, then ERR
        load(24'h221234, OP_END, OP_END, OP_END);
        pulse_start();
        push_bus(4'd2, 16'h1234, 1'b0, 1'b0, 1'b1, st_cyc + 3, 4095);
        push_res(1'b0, 1'b1, 16'h3608, 2'd0);
        run_script("timeout", 6000);
        check("err_SEL_idle", 32'({SEL, RNW, UDS_N, LDS_N}), 32'b0111);

        // restart after ERR succeeds
        ack_budget += 1;
        pulse_start();
        push_bus(4'd2, 16'h1234, 1'b0, 1'b0, 1'b1, st_cyc + 3, -1);
        push_res(1'b1, 1'b0, 16'h3608, 2'd1);
        run_script("restart", 200);

        // ROM overrun without END, with an ignored mid-script start
        load(24'h320101, 24'h300202, 24'h100303, 24'h220404);
        ack_budget += 4;
        pulse_start();
        push_bus(4'd2, 16'h0101, 1'b0, 1'b0, 1'b0, st_cyc + 3, -1);
        push_bus(4'd0, 16'h0202, 1'b0, 1'b0, 1'b0, -1, -1);
        push_bus(4'd0, 16'h0303, 1'b0, 1'b1, 1'b0, -1, -1);
        push_bus(4'd2, 16'h0404, 1'b0, 1'b0, 1'b1, -1, -1);
        push_res(1'b1, 1'b1, 16'h3608, 2'd3);
        repeat (15) @(posedge clk);
        pulse_start();
        run_script("overrun", 400);
        check("overrun_rom_addr_hold", 32'(rom_addr), 32'd3);

        // asynchronous reset in the middle of the second bus cycle
        load(24'h301111, 24'h302222, OP_END, OP_END);
        ack_budget += 1;
        pulse_start();
        push_bus(4'd0, 16'h1111, 1'b0, 1'b0, 1'b0, st_cyc + 3, -1);
        push_bus(4'd0, 16'h2222, 1'b0, 1'b0, 1'b0, -1, -1);
        push_res(1'b0, 1'b0, 16'h0000, 2'd0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (SEL === 1'b1 && rom_addr == 2'd1) break;
        end
        check("reached_second_cycle", 32'({SEL, rom_addr}), 32'b101);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check("async_rst_SEL", 32'(SEL), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_rom_addr", 32'(rom_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        CPU_RESETN = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_idle", 32'({busy, done, error, SEL}), 32'd0);
        run_script("reset", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
